vr_rr_arbiter: RTL and testbench

VR_RR_ARBITER -- requirements
Module: vr_rr_arbiter

---
 rtl/vr_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_vr_rr_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vr_rr_arbiter.sv
// Round-robin packet arbiter: N_REQ valid/ready sources merged into one registered
// output stage; a multi-beat packet holds the grant until its last beat transfers.
module vr_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  output logic [ID_W-1:0]          out_id,
  input  logic                     out_ready,
  output logic                     locked
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_lock_id;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_last;
  logic [ID_W-1:0]   r_out_id;

  logic              w_accept;
  logic              w_rr_found;
  logic [ID_W-1:0]   w_rr_idx;
  logic              w_has_grant;
  logic [ID_W-1:0]   w_grant_idx;
  logic              w_grant_valid;
  logic [WIDTH-1:0]  w_grant_data;
  logic              w_grant_last;
  logic              w_xfer;
  logic [ID_W-1:0]   w_ptr_next;

  assign w_accept = !r_out_valid || out_ready;

  // Scan offsets from the highest down so the nearest valid at or above rr_ptr wins.
  always_comb begin
    logic [ID_W:0] v_idx;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      v_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (v_idx >= (ID_W+1)'(N_REQ)) begin
        v_idx = v_idx - (ID_W+1)'(N_REQ);
      end
      if (req_valid[v_idx[ID_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = v_idx[ID_W-1:0];
      end
    end
  end

  // While locked the grant stays on lock_id even through bubbles.
  always_comb begin
    if (r_state == ST_LOCKED) begin
      w_has_grant = 1'b1;
      w_grant_idx = r_lock_id;
    end else begin
      w_has_grant = w_rr_found;
      w_grant_idx = w_rr_idx;
    end
    w_grant_valid = req_valid[w_grant_idx];
    w_grant_data  = req_data[w_grant_idx*WIDTH +: WIDTH];
    w_grant_last  = req_last[w_grant_idx];
  end

  assign w_xfer = w_has_grant && w_accept && w_grant_valid;

  always_comb begin
    if (w_grant_idx == ID_W'(N_REQ - 1)) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = w_grant_idx + 1'b1;
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && w_has_grant && w_accept) begin
      req_ready[w_grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_lock_id   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_id    <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_grant_data;
        r_out_last  <= w_grant_last;
        r_out_id    <= w_grant_idx;
        if (w_grant_last) begin
          r_state  <= ST_IDLE;
          r_rr_ptr <= w_ptr_next;
        end else if (r_state == ST_IDLE) begin
          r_state   <= ST_LOCKED;
          r_lock_id <= w_grant_idx;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_id    = r_out_id;
  assign locked    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Directed bench for vr_rr_arbiter: fairness, packet lock, backpressure,
// bubble inside a locked packet, and reset mid-packet.
module tb_vr_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [1:0]     out_id;
  logic           out_ready;
  logic           locked;

  int n_checks = 0;
  int n_errors = 0;

  vr_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_id    (out_id),
    .out_ready (out_ready),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [W-1:0] d, input logic l);
    req_valid[i]     = v;
    req_data[i*W +: W] = d;
    req_last[i]      = l;
  endtask

  task automatic chk_beat(input string tag, input logic [1:0] id, input logic [W-1:0] d,
                          input logic l, input logic lk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_id"}, 32'(out_id), 32'(id));
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_last"}, 32'(out_last), 32'(l));
    chk({tag, "_locked"}, 32'(locked), 32'(lk));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] fair_ids [5];
    fair_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst_n     = 1'b0;
    out_ready = 1'b1;
    req_valid = 4'hF;
    req_last  = 4'hF;
    req_data  = 32'h13121110;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("first_ready", 32'(req_ready), 32'b0001);

    // fairness: one single-beat packet per cycle in rotating order
    for (int b = 0; b < 5; b++) begin
      tick();
      chk_beat($sformatf("fair%0d", b), fair_ids[b], 8'h10 + W'(fair_ids[b]), 1'b1, 1'b0);
    end

    // packet lock on requester 1 (rr_ptr is now 1)
    req_valid = 4'b0000;
    set_req(0, 1'b1, 8'h01, 1'b1);
    set_req(1, 1'b1, 8'h21, 1'b0);
    set_req(2, 1'b1, 8'h02, 1'b1);
    #1;
    chk("lock_ready", 32'(req_ready), 32'b0010);
    tick();
    chk_beat("lock_b1", 2'd1, 8'h21, 1'b0, 1'b1);
    set_req(1, 1'b1, 8'h22, 1'b0);
    tick();
    chk_beat("lock_b2", 2'd1, 8'h22, 1'b0, 1'b1);
    set_req(1, 1'b1, 8'h23, 1'b1);
    tick();
    chk_beat("lock_b3", 2'd1, 8'h23, 1'b1, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    tick();
    chk_beat("lock_next2", 2'd2, 8'h02, 1'b1, 1'b0);
    tick();
    chk_beat("lock_next0", 2'd0, 8'h01, 1'b1, 1'b0);

    // backpressure (rr_ptr is now 1)
    req_valid = 4'b0000;
    set_req(1, 1'b1, 8'hA5, 1'b1);
    tick();
    chk_beat("bp_load", 2'd1, 8'hA5, 1'b1, 1'b0);
    out_ready = 1'b0;
    req_valid = 4'b0000;
    set_req(2, 1'b1, 8'h5A, 1'b1);
    #1;
    chk("bp_ready0", 32'(req_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_beat($sformatf("bp_hold%0d", c), 2'd1, 8'hA5, 1'b1, 1'b0);
      chk($sformatf("bp_ready%0d", c + 1), 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b0100);
    tick();
    chk_beat("bp_refill", 2'd2, 8'h5A, 1'b1, 1'b0);

    // bubble inside a locked packet from requester 3 (rr_ptr is now 3)
    req_valid = 4'b0000;
    set_req(3, 1'b1, 8'h31, 1'b0);
    set_req(0, 1'b1, 8'h01, 1'b1);
    tick();
    chk_beat("bub_b1", 2'd3, 8'h31, 1'b0, 1'b1);
    set_req(3, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("bub_r0_ready%0d", c), 32'(req_ready[0]), 32'd0);
      tick();
      chk($sformatf("bub_valid%0d", c), 32'(out_valid), 32'd0);
      chk($sformatf("bub_locked%0d", c), 32'(locked), 32'd1);
    end
    set_req(3, 1'b1, 8'h32, 1'b1);
    tick();
    chk_beat("bub_b2", 2'd3, 8'h32, 1'b1, 1'b0);
    set_req(3, 1'b0, 8'h00, 1'b0);
    tick();
    chk_beat("bub_r0", 2'd0, 8'h01, 1'b1, 1'b0);

    // reset in the middle of a packet from requester 2
    req_valid = 4'b0000;
    set_req(2, 1'b1, 8'h41, 1'b0);
    tick();
    chk_beat("mid_b1", 2'd2, 8'h41, 1'b0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_id", 32'(out_id), 32'd0);
    chk("mid_rst_locked", 32'(locked), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    req_valid = 4'hF;
    req_last  = 4'hF;
    req_data  = 32'h13121110;
    tick();
    rst_n = 1'b1;
    tick();
    chk_beat("post_rst", 2'd0, 8'h10, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
